// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: register offsets, STATUS bit positions, FSM encoding and reset
// constants shared by the FIR stream controller and its bench.
// Latency: n/a (declarations only).  Backpressure: n/a.
package fir_ctrl_pkg;

  // Upper address bits that select this block on the Wishbone bus.
  localparam logic [11:0] WB_BASE_HI = 12'h300;

  // Register offsets (adr[7:0]).
  localparam logic [7:0] ADR_X      = 8'h80;
  localparam logic [7:0] ADR_Y      = 8'h88;
  localparam logic [7:0] ADR_STATUS = 8'h8C;
  localparam logic [7:0] ADR_LEN    = 8'h90;

  // STATUS bit positions.
  localparam int ST_X_EMPTY = 0;
  localparam int ST_Y_FULL  = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_DONE    = 3;
  localparam int ST_ERR     = 4;

  // Block length after reset.
  localparam int LEN_RESET = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fir_state_t;

  // True for the four offsets this block answers to.
  function automatic logic is_reg_offset(input logic [7:0] off);
    return (off == ADR_X) || (off == ADR_Y) || (off == ADR_STATUS) || (off == ADR_LEN);
  endfunction

endpackage

// File: rtl/fir_stream_ctrl_if.sv
// fir_stream_ctrl_if: Wishbone slave bus plus the X (to FIR) and Y (from FIR)
// AXI-stream style channels of the FIR stream controller.
// Latency: n/a (wires only).  Backpressure: carried by ss_tready / sm_tready.
// Ports: wbs_* Wishbone, ss_* X stream out of the controller, sm_* Y stream in.
// Modport slave is the controller's view, master is the environment's view.
interface fir_stream_ctrl_if #(
  parameter int BITS = 32
);
  logic            wbs_stb_i;
  logic            wbs_cyc_i;
  logic            wbs_we_i;
  logic [3:0]      wbs_sel_i;
  logic [31:0]     wbs_adr_i;
  logic [BITS-1:0] wbs_dat_i;
  logic            wbs_ack_o;
  logic [BITS-1:0] wbs_dat_o;

  logic            ss_tvalid;
  logic            ss_tlast;
  logic [BITS-1:0] ss_tdata;
  logic            ss_tready;

  logic            sm_tvalid;
  logic            sm_tlast;
  logic [BITS-1:0] sm_tdata;
  logic            sm_tready;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output ss_tvalid, ss_tlast, ss_tdata,
    input  ss_tready,
    input  sm_tvalid, sm_tlast, sm_tdata,
    output sm_tready
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  ss_tvalid, ss_tlast, ss_tdata,
    output ss_tready,
    output sm_tvalid, sm_tlast, sm_tdata,
    input  sm_tready
  );
endinterface

// File: rtl/fir_skid_reg.sv
// fir_skid_reg: one-entry valid/ready holding register.
// Latency: out_vld rises one cycle after the input handshake.
// Backpressure: in_rdy = !full, so a fill and a drain never share a cycle.
// Ports: clk/rst, in_vld/in_dat/in_rdy upstream, out_vld/out_dat/out_rdy downstream.
module fir_skid_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);
  logic         full_q;
  logic [W-1:0] dat_q;

  assign in_rdy  = !full_q;
  assign out_vld = full_q;
  assign out_dat = dat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      dat_q  <= '0;
    end else if (in_vld && in_rdy) begin
      full_q <= 1'b1;
      dat_q  <= in_dat;
    end else if (full_q && out_rdy) begin
      full_q <= 1'b0;
    end
  end
endmodule

// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: Wishbone-mapped feeder for a streaming FIR; X words written
// by the host go out on ss_*, Y words from the FIR are read back from Y.
// Latency: STATUS/LEN ack 1 cycle after decode, X ack 2 cycles, Y ack 1 cycle
// once data is buffered. Backpressure: a full X or empty Y stalls the Wishbone
// access until it can complete or TIMEOUT cycles expire (forced ack, err set).
// Ports: wb_clk_i/wb_rst_i, bus (Wishbone + ss/sm streams), done_irq pulse.
module fir_stream_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int BITS    = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  fir_stream_ctrl_if.slave  bus,
  output logic              done_irq
);
  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  fir_state_t       state_q, state_d;
  logic [LEN_W-1:0] len_q, x_cnt, y_cnt;
  logic             err_q;
  logic             ack_q;
  logic [BITS-1:0]  dat_q;
  logic             x_ack_pend;
  logic [TO_W-1:0]  to_cnt;

  // Decode. A new access is not taken while an ack is pending or showing, so
  // a master that keeps stb up across the ack never sees two acks in a row.
  logic [7:0] off;
  logic       hit, req, we;
  assign off = bus.wbs_adr_i[7:0];
  assign we  = bus.wbs_we_i;
  assign hit = bus.wbs_stb_i && bus.wbs_cyc_i &&
               (bus.wbs_adr_i[31:20] == WB_BASE_HI) && is_reg_offset(off);
  assign req = hit && !ack_q && !x_ack_pend;

  // Byte selects and the middle address bits play no part in decode.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.wbs_sel_i, bus.wbs_adr_i[19:8]};

  logic x_wr, y_rd, st_rd, len_acc, odd_acc;
  assign x_wr    = req &&  we && (off == ADR_X);
  assign y_rd    = req && !we && (off == ADR_Y);
  assign st_rd   = req && !we && (off == ADR_STATUS);
  assign len_acc = req && (off == ADR_LEN);
  // Reads of X and writes to Y/STATUS complete immediately with no effect.
  assign odd_acc = req && !x_wr && !y_rd && !st_rd && !len_acc;

  logic             run;
  logic [LEN_W-1:0] len_eff, len_last, x_idx;
  assign run      = (state_q == S_RUN);
  assign len_eff  = (len_q == '0) ? LEN_W'(1) : len_q;
  assign len_last = len_eff - LEN_W'(1);

  // Outside RUN an X capture restarts the block, so its beat index is 0 and
  // the length limit does not apply.
  logic x_rdy, x_full, x_ok, x_cap, x_start, x_last;
  assign x_idx   = run ? x_cnt : '0;
  assign x_last  = (x_idx == len_last);
  assign x_ok    = x_rdy && (!run || (x_cnt < len_eff));
  assign x_cap   = x_wr && x_ok;
  assign x_start = x_cap && !run;

  logic [BITS:0] x_out;
  fir_skid_reg #(.W(BITS + 1)) u_x_reg (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .in_vld  (x_cap),
    .in_dat  ({x_last, bus.wbs_dat_i}),
    .in_rdy  (x_rdy),
    .out_vld (x_full),
    .out_dat (x_out),
    .out_rdy (bus.ss_tready)
  );
  assign bus.ss_tvalid = x_full;
  assign {bus.ss_tlast, bus.ss_tdata} = x_out;

  logic            y_full, y_pop, y_cap, y_last;
  logic [BITS-1:0] y_dat;
  assign y_pop  = y_rd && y_full;
  assign y_cap  = bus.sm_tvalid && bus.sm_tready;
  assign y_last = y_cap && run && ((y_cnt == len_last) || bus.sm_tlast);

  fir_skid_reg #(.W(BITS)) u_y_reg (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .in_vld  (bus.sm_tvalid),
    .in_dat  (bus.sm_tdata),
    .in_rdy  (bus.sm_tready),
    .out_vld (y_full),
    .out_dat (y_dat),
    .out_rdy (y_pop)
  );

  // Stall timer: counts consecutive stalled cycles of the current access and
  // fires on the TIMEOUT-th one. Dropping stb ends the stall and rearms it.
  logic stall, force_ack;
  assign stall     = (x_wr && !x_ok) || (y_rd && !y_full);
  assign force_ack = stall && (to_cnt == TO_W'(TIMEOUT - 1));

  logic [BITS-1:0] status_w;
  always_comb begin
    status_w             = '0;
    status_w[ST_X_EMPTY] = !x_full;
    status_w[ST_Y_FULL]  = y_full;
    status_w[ST_BUSY]    = (state_q == S_RUN);
    status_w[ST_DONE]    = (state_q == S_DONE);
    status_w[ST_ERR]     = err_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (x_cap) state_d = S_RUN;
      S_RUN:  if (y_last) state_d = S_DONE;
      S_DONE: begin
        if (x_cap)      state_d = S_RUN;
        else if (st_rd) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      x_ack_pend <= 1'b0;
      to_cnt     <= '0;
      err_q      <= 1'b0;
      len_q      <= LEN_W'(LEN_RESET);
      x_cnt      <= '0;
      y_cnt      <= '0;
      done_irq   <= 1'b0;
    end else begin
      ack_q      <= x_ack_pend || y_pop || st_rd || len_acc || odd_acc || force_ack;
      x_ack_pend <= x_cap;
      done_irq   <= y_last;

      // Read data is zero except in the ack cycle; a forced ack returns 0.
      dat_q <= '0;
      if (y_pop)             dat_q <= y_dat;
      if (st_rd)             dat_q <= status_w;
      if (len_acc && !we)    dat_q <= BITS'(len_q);
      if (len_acc && we && !run) len_q <= bus.wbs_dat_i[LEN_W-1:0];

      to_cnt <= (stall && !force_ack) ? to_cnt + TO_W'(1) : '0;

      // Set wins over the STATUS-read clear.
      if (force_ack)  err_q <= 1'b1;
      else if (st_rd) err_q <= 1'b0;

      if (x_start)    x_cnt <= LEN_W'(1);
      else if (x_cap) x_cnt <= x_cnt + LEN_W'(1);

      if (x_start)    y_cnt <= '0;
      else if (y_cap) y_cnt <= y_cnt + LEN_W'(1);
    end
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb_fir_stream_ctrl: directed bench for fir_stream_ctrl with a scoreboard of
// expected X beats and Y read data.
// Latency: n/a.  Backpressure: ss_tready driven per scenario.
module tb_fir_stream_ctrl;
  import fir_ctrl_pkg::*;

  localparam int BITS    = 32;
  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 255;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done_irq;

  always #5 clk = ~clk;

  fir_stream_ctrl_if #(.BITS(BITS)) bus ();

  fir_stream_ctrl #(.BITS(BITS), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .done_irq (done_irq)
  );

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic [BITS:0]   ss_q[$];
  logic [BITS-1:0] y_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // X stream scoreboard and done_irq counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.ss_tvalid === 1'b1 && bus.ss_tready === 1'b1) begin
      if (ss_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL ss_extra_beat observed=%0h expected=none", {bus.ss_tlast, bus.ss_tdata});
      end else begin
        check("ss_beat", 64'({bus.ss_tlast, bus.ss_tdata}), 64'(ss_q.pop_front()));
      end
    end
    if (done_irq === 1'b1) done_cnt++;
  end

  // One Wishbone access; lat is cycles from stb to ack, -1 if no ack in max_cyc.
  task automatic wb(input logic w, input logic [31:0] adr, input logic [31:0] wdat,
                    input int max_cyc, output logic [31:0] rdat, output int lat);
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = w;
    bus.wbs_sel_i = 4'hF;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
    lat  = -1;
    rdat = '0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o === 1'b1) begin
        lat  = i;
        rdat = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [7:0] off, input logic [31:0] d, input int exp_lat);
    logic [31:0] r;
    int lat;
    wb(1'b1, BASE | 32'(off), d, exp_lat + 8, r, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] exp_d, input int exp_lat);
    logic [31:0] r;
    int lat;
    wb(1'b0, BASE | 32'(off), 32'h0, exp_lat + 8, r, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_dat"}, 64'(r), 64'(exp_d));
  endtask

  task automatic send_y(input logic [31:0] d, input logic last);
    logic ok;
    ok = 1'b0;
    y_q.push_back(d);
    bus.sm_tvalid = 1'b1;
    bus.sm_tdata  = d;
    bus.sm_tlast  = last;
    for (int i = 0; i < 20; i++) begin
      if (bus.sm_tready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.sm_tvalid = 1'b0;
    bus.sm_tlast  = 1'b0;
    check("sm_handshake", 64'(ok), 64'(1));
  endtask

  task automatic rd_y(input string tag);
    logic [31:0] e;
    e = (y_q.size() != 0) ? y_q.pop_front() : 32'hDEAD_BEEF;
    rd(tag, ADR_Y, e, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int lat;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    bus.ss_tready = 1'b1;
    bus.sm_tvalid = 1'b0; bus.sm_tlast = 1'b0;  bus.sm_tdata = '0;

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 64'(bus.wbs_ack_o), 64'(0));
    check("rst_dat", 64'(bus.wbs_dat_o), 64'(0));
    check("rst_ss_tvalid", 64'(bus.ss_tvalid), 64'(0));
    check("rst_ss_tlast", 64'(bus.ss_tlast), 64'(0));
    check("rst_done_irq", 64'(done_irq), 64'(0));
    check("rst_sm_tready", 64'(bus.sm_tready), 64'(1));
    rst = 1'b0;
    rd("status_rst", ADR_STATUS, 32'h01, 1);
    rd("len_rst", ADR_LEN, 32'd64, 1);

    // LEN=4, four X beats, tlast on the last, LEN write ignored while busy.
    wr("len_wr4", ADR_LEN, 32'd4, 1);
    rd("len_rd4", ADR_LEN, 32'd4, 1);
    for (int i = 1; i <= 4; i++) begin
      ss_q.push_back({(i == 4), 32'(i)});
      wr("x_wr", ADR_X, 32'(i), 2);
    end
    wr("len_wr_busy", ADR_LEN, 32'd8, 1);
    rd("len_rd_busy", ADR_LEN, 32'd4, 1);
    rd("status_run", ADR_STATUS, 32'h05, 1);

    // Y beats with interleaved reads, then DONE and back to IDLE.
    for (int k = 1; k <= 4; k++) begin
      send_y(32'(k * 10), (k == 4));
      rd_y("y_rd");
    end
    rd("status_done", ADR_STATUS, 32'h09, 1);
    rd("status_idle", ADR_STATUS, 32'h01, 1);
    check("done_irq_once", 64'(done_cnt), 64'(1));

    // Stalled X: abort leaves no trace, forced ack after TIMEOUT sets err.
    do_reset();
    bus.ss_tready = 1'b0;
    wr("x_first", ADR_X, 32'hAAAA, 2);
    wb(1'b1, BASE | 32'(ADR_X), 32'hCCCC, 10, r, lat);
    check("x_abort_noack", 64'(lat), 64'(-1));
    rd("status_after_abort", ADR_STATUS, 32'h04, 1);
    wr("x_forced", ADR_X, 32'hBBBB, TIMEOUT);
    rd("status_err", ADR_STATUS, 32'h14, 1);
    check("ss_tdata_held", 64'(bus.ss_tdata), 64'(32'hAAAA));
    check("ss_tvalid_held", 64'(bus.ss_tvalid), 64'(1));
    check("ss_tlast_held", 64'(bus.ss_tlast), 64'(0));
    rd("status_err_clr", ADR_STATUS, 32'h04, 1);
    rd("y_forced", ADR_Y, 32'h0, TIMEOUT);
    rd("status_err_y", ADR_STATUS, 32'h14, 1);

    // LEN=0 acts as a one-beat block.
    do_reset();
    bus.ss_tready = 1'b1;
    wr("len_wr0", ADR_LEN, 32'd0, 1);
    ss_q.push_back({1'b1, 32'h55});
    wr("x_len0", ADR_X, 32'h55, 2);
    send_y(32'h77, 1'b0);
    rd_y("y_len0");
    rd("status_done_len0", ADR_STATUS, 32'h09, 1);
    check("done_irq_twice", 64'(done_cnt), 64'(2));

    // Unmapped offset and wrong base: no ack, no state change.
    wb(1'b1, BASE | 32'h84, 32'h1, 8, r, lat);
    check("bad_off_noack", 64'(lat), 64'(-1));
    wb(1'b1, 32'h3010_0090, 32'h5, 8, r, lat);
    check("bad_base_noack", 64'(lat), 64'(-1));
    rd("len_rd_zero", ADR_LEN, 32'd0, 1);

    // Reset mid-stream with a third X beat held and its ack pending.
    do_reset();
    wr("len_wr4_d", ADR_LEN, 32'd4, 1);
    ss_q.push_back({1'b0, 32'd1});
    wr("x_d1", ADR_X, 32'd1, 2);
    ss_q.push_back({1'b0, 32'd2});
    wr("x_d2", ADR_X, 32'd2, 2);
    bus.ss_tready = 1'b0;
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = BASE | 32'(ADR_X); bus.wbs_dat_i = 32'd3;
    @(posedge clk); #1;
    check("x3_held", 64'(bus.ss_tvalid), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ack", 64'(bus.wbs_ack_o), 64'(0));
    check("midrst_ss_tvalid", 64'(bus.ss_tvalid), 64'(0));
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("postrst_ack", 64'(bus.wbs_ack_o), 64'(0));
    check("postrst_sm_tready", 64'(bus.sm_tready), 64'(1));
    rd("status_postrst", ADR_STATUS, 32'h01, 1);
    rd("len_postrst", ADR_LEN, 32'd64, 1);

    check("ss_queue_empty", 64'(ss_q.size()), 64'(0));
    check("y_queue_empty", 64'(y_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_stream_ctrl.md
FIR_STREAM_CTRL -- requirements
Module: fir_stream_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 32, Wishbone and stream data width.
REQ-002 SHALL have parameter LEN_W, default 16, length register and beat-counter width.
REQ-003 SHALL have parameter TIMEOUT, default 255, cycles a stalled X/Y access waits before a forced ack.
REQ-004 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write-enable.
REQ-007 wbs_sel_i  in  4  byte selects; ignored, full-word access only.
REQ-008 wbs_adr_i  in  32  byte address.
REQ-009 wbs_dat_i  in  BITS  write data.
REQ-010 wbs_ack_o  out  1  registered single-cycle ack.
REQ-011 wbs_dat_o  out  BITS  read data; valid in the ack cycle, 0 otherwise.
REQ-012 ss_tvalid, ss_tlast  out  1 each; ss_tdata  out  BITS; ss_tready  in  1  (X stream to FIR).
REQ-013 sm_tvalid, sm_tlast  in  1 each; sm_tdata  in  BITS; sm_tready  out  1  (Y stream from FIR).
REQ-014 done_irq  out  1  one-cycle pulse when the last Y is captured.

Function
REQ-015 Decode SHALL be stb&cyc & adr[31:20]==0x300 & adr[7:0] in {0x80,0x88,0x8C,0x90}; other addresses get no ack and leave all state unchanged.
REQ-016 Register map: 0x80 X (WO), 0x88 Y (RO), 0x8C STATUS (RO), 0x90 LEN (RW, LEN_W bits, zero-extended on read).
REQ-017 Ack SHALL assert for one cycle per access and never on two consecutive cycles.
REQ-018 STATUS, LEN read, and LEN write SHALL ack exactly 1 cycle after decode.
REQ-019 STATUS bits: [0] x_empty, [1] y_full, [2] busy (state RUN), [3] done (state DONE), [4] err; all others 0.
REQ-020 X register (1 entry): ss_tvalid = x_full; ss_tdata = X; x_full clears on ss_tvalid&ss_tready.
REQ-021 An X write SHALL be captured only when x_full=0 and x_cnt<LEN; ack follows capture by 1 cycle, and x_cnt increments on capture.
REQ-022 ss_tlast SHALL be 1 while the held beat has index LEN-1.
REQ-023 Y buffer (1 entry): sm_tready = !y_full; capture on sm_tvalid&sm_tready; y_cnt increments on capture.
REQ-024 A Y read SHALL wait until y_full=1, ack 1 cycle later with the buffered data, and clear y_full in the ack cycle.
REQ-025 Capture and pop never coincide; the resulting one-cycle bubble is required.
REQ-026 FSM IDLE->RUN on X capture, clearing x_cnt/y_cnt before counting.
REQ-027 FSM RUN->DONE when the captured Y has y_cnt==LEN-1 or sm_tlast=1; done_irq pulses in that cycle.
REQ-028 FSM DONE->IDLE on STATUS read; DONE->RUN on X capture (counters restart); a simultaneous STATUS read is overridden by X capture.
REQ-029 A LEN write while in RUN SHALL be acked and ignored; LEN=0 SHALL be treated as 1.
REQ-030 A stalled X write or Y read SHALL be force-acked after TIMEOUT cycles, writing nothing (X) or returning 0 (Y), and setting err.
REQ-031 err is sticky and clears on STATUS read; a set and a clear in the same cycle leave err=1.
REQ-032 A Wishbone master dropping stb mid-stall SHALL abort the access with no ack and no state change.

Reset
REQ-033 On wb_rst_i: FSM=IDLE, LEN=64, x_full=y_full=err=0, counters and timeout counter=0; wbs_ack_o, wbs_dat_o, ss_tvalid, ss_tlast, done_irq=0; sm_tready=1 from the first post-reset cycle.
REQ-034 Reset mid-stream SHALL discard held X/Y data with no ack issued.

Structure
REQ-035 Package fir_ctrl_pkg SHALL hold the register offsets, STATUS bit indices, FSM state enum, and LEN reset value.
REQ-036 One sub-module, fir_skid_reg, SHALL be the 1-entry valid/ready buffer, instanced for X and for Y.

Verification
REQ-037 LEN=4, write X 1,2,3,4 with ss_tready=1 -> 4 beats on ss, tlast only on 4, each ack 2 cycles after stb.
REQ-038 FIR returns Y 10,20,30,40 with Y reads interleaved -> reads return 10,20,30,40, done_irq pulses once, STATUS=0x09, then STATUS reads 0x01.
REQ-039 ss_tready=0, two X writes -> first acked, second force-acked after 255 cycles, STATUS bit4=1, ss_tdata still the first value.
REQ-040 LEN write 8 while busy -> acked, LEN read returns 4; LEN write 0 in IDLE -> one beat carries tlast.
REQ-041 Reset asserted after 2 of 4 X beats -> STATUS=0x01, no ack, ss_tvalid=0 next cycle, LEN reads 64.
